dcm_clkdv_ps: RTL and testbench
===============================

Name: dcm_clkdv_ps

Overview:
- Parametrised clock-divide, lock-qualification and phase-shift block for the DCM simulation models, clocked from the model's internal 2x clock.
- Produces a 50%-duty CLKDV output (CLKIN / CLKDV_DIVIDE), a qualified LOCKED flag and an 8-bit STATUS word.
- Implements the PSEN/PSINCDEC/PSDONE variable phase-shift handshake, which moves CLKDV edges in clk2x-cycle steps.
- Sits between the PLL_sim instances, which supply lock_in, and the DCM wrapper outputs.

Parameters:
- CLKDV_DIVIDE, 2, integer 2..16; CLKDV period = 2*CLKDV_DIVIDE clk2x cycles.
- LOCK_CYCLES, 16, consecutive clk2x cycles of lock_in high required before locked asserts.
- PS_MAX, 255, magnitude limit of the signed phase offset, in steps.
- PS_W, 9, width of ps_offset; must hold ±PS_MAX.
- PS_LATENCY, 3, clk2x cycles from psen acceptance to the psdone pulse; legal range 1..15.

Ports:
- clk2x  in  1  clock, 2x CLKIN.
- resetb  in  1  asynchronous, active-low reset.
- lock_in  in  1  raw lock from the upstream PLL models.
- psen  in  1  phase-shift request, single-cycle pulse.
- psincdec  in  1  1 = increment (delay), 0 = decrement (advance); sampled with psen.
- psdone  out  1  one-cycle completion pulse.
- clkdv  out  1  divided clock, registered.
- locked  out  1  qualified lock.
- ps_offset  out  PS_W  signed current phase offset.
- status  out  8  [0] phase-shift overflow, [1] lock-lost sticky, [7:2] = 0.

Behaviour:
- Reset (resetb low, async): clkdv=0, locked=0, psdone=0, ps_offset=0, status=0, lock FSM in WAIT_LOCK, divide counter cnt=0, PS engine idle.
- Lock FSM states:
  - WAIT_LOCK: lock_in sampled high -> COUNT, run counter=1.
  - COUNT: counter increments while lock_in is high; lock_in low -> WAIT_LOCK; counter reaching LOCK_CYCLES -> LOCKED, with locked registered high that edge. locked therefore first reads 1 LOCK_CYCLES cycles after the first high sample.
  - LOCKED: lock_in low -> WAIT_LOCK, locked=0 at the next edge, status[1]=1 (sticky until reset).
- Divider:
  - Outside LOCKED: cnt held at 0 and clkdv=0.
  - In LOCKED: cnt runs 0..2D-1 and wraps, with D = CLKDV_DIVIDE.
  - clkdv register = (cnt_next < D), so the first LOCKED cycle shows clkdv=1. The output is high D cycles, then low D cycles.
- Phase-shift handshake:
  - psen is accepted only when locked=1 and the engine is idle. psen while busy or unlocked is ignored, with no psdone.
  - On acceptance, the step is applied on the following cycle. Increment holds cnt for one cycle, delaying every later clkdv edge by 1 clk2x cycle. Decrement advances cnt by 2 (mod 2D) for one cycle.
  - Saturation: if ps_offset is already +PS_MAX (increment) or -PS_MAX (decrement), no step is applied, ps_offset is unchanged and status[0]=1. status[0] clears on the next non-saturating accepted step.
  - psdone pulses exactly PS_LATENCY cycles after the acceptance edge, for one cycle. The engine returns to idle that same cycle, so psen on the cycle psdone is high is accepted.
  - Lock lost while busy: the pending step is abandoned (if not yet applied), no psdone is issued, ps_offset is retained and the engine goes idle.
- psen on the same cycle lock_in drops while in LOCKED: accepted (locked is still 1). The step is then dropped per the rule above.
- Re-lock: the divider restarts from cnt=0. ps_offset is retained; the offset does not re-apply to the phase.

Decomposition:
- Package dcm_sim_pkg holds:
  - lock FSM enum {WAIT_LOCK, COUNT, LOCKED};
  - STATUS bit index constants (ST_PS_OVF=0, ST_LOCK_LOST=1);
  - a function for minimum signed width of ±PS_MAX.
- One sub-module, dcm_ps_ctrl, contains the handshake, the latency counter, ps_offset saturation and the overflow flag. It emits step_inc/step_dec strobes to the divider.

Test Plan:
- D=3, LOCK_CYCLES=16: release reset, hold lock_in=1 -> locked rises 16 cycles after the first high sample; clkdv pattern 111000 repeating from the first locked cycle.
- lock_in glitches low at count 10 -> counter restarts; locked rises 16 cycles after the re-high, never earlier.
- Locked, D=3: psen+psincdec=1 -> psdone exactly 3 cycles later, ps_offset=1, the next clkdv rising edge 7 cycles after the previous one (not 6). Decrement -> period 5, ps_offset back to 0.
- PS_MAX=2: issue 3 increments -> ps_offset=2, third psdone still pulses, status[0]=1. One decrement -> ps_offset=1, status[0]=0.
- psen during busy -> ignored, single psdone. psen while unlocked -> no psdone, ps_offset unchanged.
- Drop lock_in one cycle after psen acceptance -> no psdone, locked=0 next edge, status[1]=1 and stays set until resetb pulses low mid-operation; after that all outputs return to reset values immediately.

Source files
------------

// File: rtl/dcm_clkdv_ps_pkg.sv
// Shared types and constants for the DCM clock-divide / phase-shift block.
// Lock FSM states, STATUS bit positions and a width helper.
package dcm_sim_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        COUNT,
        LOCKED
    } lock_st_e;

    localparam int ST_PS_OVF    = 0;
    localparam int ST_LOCK_LOST = 1;

    // Bits needed for a signed value spanning -m..+m.
    function automatic int ps_width(input int m);
        return $clog2(m + 1) + 1;
    endfunction

endpackage

// File: rtl/dcm_clkdv_ps_if.sv
// Phase-shift request/completion bundle between the DCM wrapper and the
// divider block; the wrapper is master, dcm_clkdv_ps is slave.
interface dcm_clkdv_ps_if #(
    parameter int PS_W = dcm_sim_pkg::ps_width(255)
);
    logic                   psen;
    logic                   psincdec;
    logic                   psdone;
    logic signed [PS_W-1:0] ps_offset;

    modport master (
        output psen,
        output psincdec,
        input  psdone,
        input  ps_offset
    );

    modport slave (
        input  psen,
        input  psincdec,
        output psdone,
        output ps_offset
    );
endinterface

// File: rtl/dcm_clkdv_ps_ps_ctrl.sv
// Phase-shift engine: accepts one request at a time, applies it one cycle
// later as a divider strobe, saturates the offset and times psdone.
module dcm_ps_ctrl #(
    parameter int PS_MAX     = 255,
    parameter int PS_W       = 9,
    parameter int PS_LATENCY = 3
) (
    input  logic                   clk2x,
    input  logic                   resetb,
    input  logic                   psen_i,
    input  logic                   psincdec_i,
    input  logic                   locked_i,
    input  logic                   lock_ok_i,
    output logic                   psdone_o,
    output logic signed [PS_W-1:0] ps_offset_o,
    output logic                   ovf_o,
    output logic                   step_inc_o,
    output logic                   step_dec_o
);
    localparam int LW = $clog2(PS_LATENCY + 1);
    localparam logic signed [PS_W-1:0] P_HI = PS_W'(PS_MAX);
    localparam logic signed [PS_W-1:0] P_LO = PS_W'(-PS_MAX);

    logic                   busy_q, busy_d;
    logic                   pend_q, pend_d;
    logic                   dir_q, dir_d;
    logic [LW-1:0]          lat_q, lat_d;
    logic                   done_q, done_d;
    logic signed [PS_W-1:0] off_q, off_d;
    logic                   ovf_q, ovf_d;
    logic                   sat;

    // Engine state registers.
    always_ff @(posedge clk2x or negedge resetb) begin
        if (!resetb) begin
            busy_q <= 1'b0;
            pend_q <= 1'b0;
            dir_q  <= 1'b0;
            lat_q  <= '0;
            done_q <= 1'b0;
            off_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
            dir_q  <= dir_d;
            lat_q  <= lat_d;
            done_q <= done_d;
            off_q  <= off_d;
            ovf_q  <= ovf_d;
        end
    end

    // Accept, apply (unless lock is going away), count latency, abort.
    always_comb begin
        sat    = dir_q ? (off_q == P_HI) : (off_q == P_LO);
        busy_d = busy_q;
        pend_d = 1'b0;
        dir_d  = dir_q;
        lat_d  = lat_q;
        done_d = 1'b0;
        off_d  = off_q;
        ovf_d  = ovf_q;
        if (pend_q && lock_ok_i) begin
            if (sat) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = 1'b0;
                off_d = dir_q ? off_q + 1'b1 : off_q - 1'b1;
            end
        end
        if (busy_q) begin
            if (!lock_ok_i) begin
                busy_d = 1'b0;
            end else if (lat_q == LW'(PS_LATENCY)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                lat_d = lat_q + 1'b1;
            end
        end else if (psen_i && locked_i) begin
            busy_d = 1'b1;
            pend_d = 1'b1;
            dir_d  = psincdec_i;
            lat_d  = LW'(1);
        end
    end

    assign step_inc_o  = pend_q && dir_q && !sat;
    assign step_dec_o  = pend_q && !dir_q && !sat;
    assign psdone_o    = done_q;
    assign ps_offset_o = off_q;
    assign ovf_o       = ovf_q;

endmodule

// File: rtl/dcm_clkdv_ps.sv
// Clock divider with lock qualification and phase-shift stepping,
// clocked from the DCM model's internal 2x clock.
module dcm_clkdv_ps
    import dcm_sim_pkg::*;
#(
    parameter int CLKDV_DIVIDE = 2,
    parameter int LOCK_CYCLES  = 16,
    parameter int PS_MAX       = 255,
    parameter int PS_W         = 9,
    parameter int PS_LATENCY   = 3
) (
    input  logic                 clk2x,
    input  logic                 resetb,
    input  logic                 lock_in_i,
    dcm_clkdv_ps_if.slave        ps_if,
    output logic                 clkdv_o,
    output logic                 locked_o,
    output logic [7:0]           status_o
);
    localparam int D  = CLKDV_DIVIDE;
    localparam int DW = $clog2(2 * D);
    localparam int CW = $clog2(LOCK_CYCLES + 1);
    localparam logic [DW:0] TWO_D = (DW + 1)'(2 * D);
    localparam logic [DW:0] D_V   = (DW + 1)'(D);

    lock_st_e      st_q, st_d;
    logic [CW-1:0] run_q, run_d;
    logic          locked_q, locked_d;
    logic          lost_q, lost_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          clkdv_q, clkdv_d;
    logic [DW:0]   adv, nxt;
    logic          step_inc, step_dec, ps_ovf;

    // Lock FSM, divider and sticky lock-lost registers.
    always_ff @(posedge clk2x or negedge resetb) begin
        if (!resetb) begin
            st_q     <= WAIT_LOCK;
            run_q    <= '0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
            cnt_q    <= '0;
            clkdv_q  <= 1'b0;
        end else begin
            st_q     <= st_d;
            run_q    <= run_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
            cnt_q    <= cnt_d;
            clkdv_q  <= clkdv_d;
        end
    end

    // Qualify lock_in: a full run of high samples before declaring lock.
    always_comb begin
        st_d   = st_q;
        run_d  = run_q;
        lost_d = lost_q;
        unique case (st_q)
            WAIT_LOCK: begin
                if (lock_in_i) begin
                    st_d  = COUNT;
                    run_d = CW'(1);
                end
            end
            COUNT: begin
                if (!lock_in_i) begin
                    st_d  = WAIT_LOCK;
                    run_d = '0;
                end else if (run_q == CW'(LOCK_CYCLES)) begin
                    st_d = LOCKED;
                end else begin
                    run_d = run_q + 1'b1;
                end
            end
            LOCKED: begin
                if (!lock_in_i) begin
                    st_d   = WAIT_LOCK;
                    run_d  = '0;
                    lost_d = 1'b1;
                end
            end
            default: st_d = WAIT_LOCK;
        endcase
        locked_d = (st_d == LOCKED);
    end

    // Divide counter: hold on increment, skip one on decrement.
    always_comb begin
        adv = (DW + 1)'(1);
        if (step_inc) begin
            adv = '0;
        end else if (step_dec) begin
            adv = (DW + 1)'(2);
        end
        nxt = {1'b0, cnt_q} + adv;
        if (nxt >= TWO_D) begin
            nxt = nxt - TWO_D;
        end
        cnt_d   = '0;
        clkdv_d = 1'b0;
        if (locked_d) begin
            if (locked_q) begin
                cnt_d = nxt[DW-1:0];
            end
            clkdv_d = ({1'b0, cnt_d} < D_V);
        end
    end

    dcm_ps_ctrl #(
        .PS_MAX     (PS_MAX),
        .PS_W       (PS_W),
        .PS_LATENCY (PS_LATENCY)
    ) u_ps (
        .clk2x       (clk2x),
        .resetb      (resetb),
        .psen_i      (ps_if.psen),
        .psincdec_i  (ps_if.psincdec),
        .locked_i    (locked_q),
        .lock_ok_i   (locked_d),
        .psdone_o    (ps_if.psdone),
        .ps_offset_o (ps_if.ps_offset),
        .ovf_o       (ps_ovf),
        .step_inc_o  (step_inc),
        .step_dec_o  (step_dec)
    );

    // Pack the status word.
    always_comb begin
        status_o               = '0;
        status_o[ST_PS_OVF]    = ps_ovf;
        status_o[ST_LOCK_LOST] = lost_q;
    end

    assign clkdv_o  = clkdv_q;
    assign locked_o = locked_q;

endmodule

// File: tb/tb_dcm_clkdv_ps.sv
// Bench for dcm_clkdv_ps: directed handshake scenarios then random
// lock/phase-shift traffic against a cycle-level reference model.
module tb_dcm_clkdv_ps;
    localparam int D    = 3;
    localparam int LC   = 16;
    localparam int PMAX = 2;
    localparam int PW   = 9;
    localparam int LAT  = 3;

    logic       clk2x  = 1'b0;
    logic       resetb = 1'b0;
    logic       lock_in = 1'b0;
    logic       clkdv, locked;
    logic [7:0] status;

    dcm_clkdv_ps_if #(.PS_W(PW)) ps_if ();

    dcm_clkdv_ps #(
        .CLKDV_DIVIDE (D),
        .LOCK_CYCLES  (LC),
        .PS_MAX       (PMAX),
        .PS_W         (PW),
        .PS_LATENCY   (LAT)
    ) dut (
        .clk2x     (clk2x),
        .resetb    (resetb),
        .lock_in_i (lock_in),
        .ps_if     (ps_if.slave),
        .clkdv_o   (clkdv),
        .locked_o  (locked),
        .status_o  (status)
    );

    always #5 clk2x = ~clk2x;

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: lock = current run of high samples exceeds LC;
    // divider phase = cycles since lock plus net applied shift, mod 2D.
    int  h, t, s, m_off, cyc, app_at, done_at;
    bit  m_locked, m_ovf, m_lost, m_done, pend, pdir;

    task automatic m_reset();
        h = 0; t = 0; s = 0; m_off = 0;
        m_locked = 0; m_ovf = 0; m_lost = 0; m_done = 0; pend = 0;
    endtask

    task automatic m_edge(input bit li, input bit pe, input bit pd);
        bit was_locked, was_pend;
        was_locked = m_locked;
        was_pend   = pend;
        cyc++;
        h = li ? h + 1 : 0;
        m_locked = (h > LC);
        if (was_locked && !li) m_lost = 1;
        m_done = 0;
        if (m_locked && was_locked) t++;
        else begin t = 0; s = 0; end
        if (pend) begin
            if (!m_locked) pend = 0;
            else begin
                if (cyc == app_at) begin
                    if ((pdir && m_off == PMAX) || (!pdir && m_off == -PMAX))
                        m_ovf = 1;
                    else begin
                        m_ovf = 0;
                        m_off += pdir ? 1 : -1;
                        s     += pdir ? -1 : 1;
                    end
                end
                if (cyc == done_at) begin
                    m_done = 1;
                    pend   = 0;
                end
            end
        end
        if (!was_pend && pe && was_locked) begin
            pend = 1; pdir = pd;
            app_at = cyc + 1; done_at = cyc + LAT;
        end
    endtask

    function automatic bit m_clkdv();
        int ph;
        ph = ((t + s) % (2 * D) + 2 * D) % (2 * D);
        return m_locked && (ph < D);
    endfunction

    int tcyc = 0, last_rise = -1, pmin = 99, pmax = 0, n_done = 0;
    bit prev_clkdv = 0;

    task automatic check_all();
        chk("clkdv", clkdv, m_clkdv());
        chk("locked", locked, m_locked);
        chk("psdone", ps_if.psdone, m_done);
        chk("ps_offset", ps_if.ps_offset, m_off);
        chk("status", status, {6'b0, m_lost, m_ovf});
        if (ps_if.psdone) n_done++;
        if (!locked) last_rise = -1;
        else if (clkdv && !prev_clkdv) begin
            if (last_rise >= 0) begin
                if (tcyc - last_rise < pmin) pmin = tcyc - last_rise;
                if (tcyc - last_rise > pmax) pmax = tcyc - last_rise;
            end
            last_rise = tcyc;
        end
        prev_clkdv = clkdv;
    endtask

    task automatic cyc_run(input bit li, input bit pe, input bit pd);
        lock_in = li;
        ps_if.psen = pe;
        ps_if.psincdec = pd;
        @(posedge clk2x);
        tcyc++;
        if (resetb) m_edge(li, pe, pd);
        @(negedge clk2x);
        check_all();
    endtask

    task automatic run_n(input int n, input bit li);
        for (int i = 0; i < n; i++) cyc_run(li, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        m_reset();
        #1 check_all();
        run_n(2, 1'b0);
        resetb = 1'b1;
    endtask

    initial begin
        int n, k, d0;
        logic [5:0] pat;
        ps_if.psen = 1'b0;
        ps_if.psincdec = 1'b0;
        cyc = 0;
        m_reset();
        @(negedge clk2x);
        check_all();
        do_reset();
        run_n(3, 1'b0);

        // Glitch low after 10 high samples, then measure lock latency.
        run_n(10, 1'b1);
        run_n(1, 1'b0);
        n = 0;
        do begin
            cyc_run(1'b1, 1'b0, 1'b0);
            n++;
        end while (!locked && n < 40);
        chk("lock_latency", n - 1, LC);
        pat = {5'b0, clkdv};
        for (int i = 0; i < 5; i++) begin
            cyc_run(1'b1, 1'b0, 1'b0);
            pat = {pat[4:0], clkdv};
        end
        chk("clkdv_pattern", pat, 6'b111000);
        run_n(10, 1'b1);

        // Increment: psdone latency, one stretched period.
        pmin = 99; pmax = 0;
        cyc_run(1'b1, 1'b1, 1'b1);
        k = 0;
        do begin
            cyc_run(1'b1, 1'b0, 1'b0);
            k++;
        end while (!ps_if.psdone && k < 8);
        chk("psdone_latency", k, LAT);
        run_n(12, 1'b1);
        chk("period_inc", pmax, 2 * D + 1);
        chk("offset_inc", ps_if.ps_offset, 1);

        // Decrement: one shortened period.
        pmin = 99; pmax = 0;
        cyc_run(1'b1, 1'b1, 1'b0);
        run_n(14, 1'b1);
        chk("period_dec", pmin, 2 * D - 1);
        chk("offset_dec", ps_if.ps_offset, 0);

        // Saturation at +PMAX, then recovery.
        d0 = n_done;
        for (int i = 0; i < 3; i++) begin
            cyc_run(1'b1, 1'b1, 1'b1);
            run_n(4, 1'b1);
        end
        chk("sat_done_count", n_done - d0, 3);
        chk("sat_offset", ps_if.ps_offset, PMAX);
        chk("sat_ovf", status[0], 1);
        cyc_run(1'b1, 1'b1, 1'b0);
        run_n(4, 1'b1);
        chk("unsat_offset", ps_if.ps_offset, PMAX - 1);
        chk("unsat_ovf", status[0], 0);

        // Request while busy is ignored.
        d0 = n_done;
        cyc_run(1'b1, 1'b1, 1'b1);
        cyc_run(1'b1, 1'b1, 1'b0);
        run_n(5, 1'b1);
        chk("busy_done_count", n_done - d0, 1);
        chk("busy_offset", ps_if.ps_offset, PMAX);

        // Lock drops right after acceptance.
        d0 = n_done;
        cyc_run(1'b1, 1'b1, 1'b0);
        cyc_run(1'b0, 1'b0, 1'b0);
        chk("drop_locked", locked, 0);
        run_n(4, 1'b0);
        chk("drop_done_count", n_done - d0, 0);
        chk("drop_offset", ps_if.ps_offset, PMAX);
        chk("drop_lost", status[1], 1);

        // Request while unlocked.
        d0 = n_done;
        cyc_run(1'b0, 1'b1, 1'b1);
        run_n(4, 1'b0);
        chk("unlocked_done_count", n_done - d0, 0);

        // Re-lock keeps offset and sticky flag; then reset mid-request.
        run_n(24, 1'b1);
        chk("relock_locked", locked, 1);
        chk("relock_lost", status[1], 1);
        chk("relock_offset", ps_if.ps_offset, PMAX);
        cyc_run(1'b1, 1'b1, 1'b0);
        do_reset();

        // Random traffic.
        k = 0;
        for (int i = 0; i < 4000; i++) begin
            bit li, pe, pd;
            if (k > 0) k--;
            else if ($urandom_range(299) == 0) k = $urandom_range(5, 1);
            li = (k == 0);
            pe = ($urandom_range(4) == 0);
            pd = 1'($urandom_range(1));
            if ($urandom_range(1499) == 0) do_reset();
            else cyc_run(li, pe, pd);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
